p2_hazard_ctrl: RTL and testbench
=================================

# p2_hazard_ctrl

Pipeline hazard controller that produces the hold and clear controls consumed by the IF/ID and ID/EX stage registers and the PC.
- Keeps a shift-register scoreboard of destination registers still in flight from EX to writeback.
- Stalls decode on read-after-write conflicts.
- Holds the front end while a multi-cycle EX operation is busy.
- Flushes younger instructions on a taken branch.
- Sits beside the decode stage. Its `idex_flush` and `idex_stall` drive the ID/EX register's synchronous clear and stall inputs.

## Interface
- `DEPTH`, 3: scoreboard entries (EX, MEM, WB); legal 2–6.
- `MC_CYCLES`, 4: total EX cycles of a multi-cycle op; legal 2–15.
- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low.
- `id_valid` in 1: decode holds a real instruction.
- `id_rs1`, `id_rs2` in 5 each: source register addresses.
- `id_uses_rs1`, `id_uses_rs2` in 1 each: the sources are actually read.
- `id_rd` in 5: destination address.
- `id_writes_rd` in 1: instruction writes `id_rd`.
- `id_is_load` in 1: instruction is a load.
- `id_multicycle` in 1: instruction needs `MC_CYCLES` EX cycles.
- `ex_branch_taken` in 1: instruction in EX redirects the PC this cycle.
- `pc_stall` out 1: hold the PC.
- `ifid_stall` out 1: hold IF/ID.
- `ifid_flush` out 1: clear IF/ID.
- `idex_stall` out 1: hold ID/EX.
- `idex_flush` out 1: load a bubble into ID/EX (type 7).
- `ex_busy` out 1: multi-cycle op is occupying EX.

## Operation
- **State.**
  - Scoreboard `sb[0..DEPTH-1]`, each entry `{v, rd[4:0], ld}`. `sb[0]` is the instruction currently in EX.
  - 4-bit busy counter `mc_cnt`.
- **Match.** `match(r)` is true if `r != 0` and some `sb[i]` has `v=1` and `rd == r`. Register x0 never hazards.
- **RAW condition.** `raw = id_valid & ((id_uses_rs1 & match(id_rs1)) | (id_uses_rs2 & match(id_rs2)))`.
- **Busy.** `ex_busy = (mc_cnt != 0)`.
- **Priority (highest first), outputs combinational:**
  - `ex_branch_taken` and not busy:
    - `ifid_flush=1`, `idex_flush=1`.
    - `pc_stall=0`, `ifid_stall=0`, `idex_stall=0`.
    - A `raw` in the same cycle is ignored.
  - busy: `pc_stall=1`, `ifid_stall=1`, `idex_stall=1`, flushes 0.
  - `raw`: `pc_stall=1`, `ifid_stall=1`, `idex_flush=1` (bubble into EX), `idex_stall=0`.
  - otherwise: all 0.
- **Issue.** Issue happens at the edge where `id_valid` is high and none of branch, busy or `raw` applies.
- **Scoreboard shift when not busy.**
  - `sb[i+1] <= sb[i]`; `sb[DEPTH-1]` drops out.
  - On issue, `sb[0] <= {id_writes_rd & (id_rd != 0), id_rd, id_is_load}`; otherwise `sb[0] <= bubble (v=0)`.
- **Scoreboard shift when busy.**
  - `sb[0]` holds.
  - `sb[i+1] <= sb[i]` for `i ≥ 1`.
  - `sb[1] <= bubble`.
- **Busy counter.**
  - Issue with `id_multicycle`: `mc_cnt <= MC_CYCLES-1`.
  - While `mc_cnt > 0`: decrement by 1 per cycle. It saturates at 0.
- **Reset.**
  - Asserting `reset` low immediately clears all `sb` entries and `mc_cnt`.
  - While `reset` is low, outputs are forced to `idex_flush=1`, `ifid_flush=1`, all others 0. This applies mid-operation and on abort of a multi-cycle op.

## Timing
- Stall and flush outputs are combinational from state and the current `id_*` / `ex_*` inputs. They are valid in the same cycle the condition arises.
- A consumer of register rd stalls for as many cycles as its producer has scoreboard entries left to traverse. With `DEPTH=3` and a back-to-back dependency, the consumer stalls 3 cycles.
- A multi-cycle op issued at edge T keeps `ex_busy` high for cycles T+1 … T+`MC_CYCLES`-1.
- A branch flush lasts exactly the cycle `ex_branch_taken` is high. There is no extra penalty cycle.
- `ex_branch_taken` is asserted only by a non-busy instruction in EX. Assertion while busy is ignored.

## Configuration
- **`HAZ_FWD_EN` defined:** EX/MEM results are forwarded, so `match(r)` considers only a `sb[0]` entry with `v=1`, `ld=1` and `rd == r`. Only load-use conflicts stall, for exactly 1 cycle.
- **`HAZ_FWD_EN` undefined:** all `DEPTH` entries are checked as described above. The `ld` field is stored but unused.

## Test plan
- Reset low mid-stream, then release:
  - While low: `idex_flush=1`, `ifid_flush=1`, `pc_stall=0`.
  - After release with `id_valid=0`: all outputs 0.
- Issue `add x5` with `id_writes_rd=1`, then next cycle an instruction reading `rs1=x5`:
  - Without FWD: `pc_stall`, `ifid_stall`, `idex_flush` all high for 3 cycles, then the consumer issues.
  - With FWD: 0 stall cycles.
- Load `x7`, then a dependent use of `x7`:
  - With FWD: exactly 1 stall cycle.
  - A dependency on x0 never stalls in either mode.
- Multi-cycle op with `MC_CYCLES=4` issued at edge T:
  - `ex_busy`, `idex_stall` and `pc_stall` high for cycles T+1..T+3, then drop.
  - The next independent instruction issues at edge T+4.
- `ex_branch_taken=1` in the same cycle as a RAW conflict: `ifid_flush=1`, `idex_flush=1`, `pc_stall=0`. The decode instruction is not entered in the scoreboard.
- Reset asserted during a multi-cycle op with `mc_cnt=2`: `ex_busy` drops immediately and the scoreboard is empty after release.

Source files
------------

// File: rtl/p2_hazard_ctrl.sv
// Hazard controller: RAW scoreboard, multi-cycle EX hold and branch flush for the IF/ID, ID/EX and PC controls.
// Optional build macro HAZ_FWD_EN: with forwarding, only a load in EX can stall the consumer in decode.
module p2_hazard_ctrl #(
   parameter int DEPTH     = 3,
   parameter int MC_CYCLES = 4
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       id_valid,
   input  logic [4:0] id_rs1,
   input  logic [4:0] id_rs2,
   input  logic       id_uses_rs1,
   input  logic       id_uses_rs2,
   input  logic [4:0] id_rd,
   input  logic       id_writes_rd,
   input  logic       id_is_load,
   input  logic       id_multicycle,
   input  logic       ex_branch_taken,
   output logic       pc_stall,
   output logic       ifid_stall,
   output logic       ifid_flush,
   output logic       idex_stall,
   output logic       idex_flush,
   output logic       ex_busy
);

   localparam logic [3:0] MC_LOAD = 4'(MC_CYCLES - 1);

   logic [DEPTH-1:0]      sb_v_reg;
   logic [DEPTH-1:0]      sb_v_next;
   logic [DEPTH-1:0][4:0] sb_rd_reg;
   logic [DEPTH-1:0][4:0] sb_rd_next;
   logic [DEPTH-1:0]      sb_ld_reg;
   logic [DEPTH-1:0]      sb_ld_next;
   logic [3:0]            mc_cnt_reg;
   logic [3:0]            mc_cnt_next;
   logic                  busy;
   logic                  match_rs1;
   logic                  match_rs2;
   logic                  raw;
   logic                  issue;
   logic                  sb_unused;

   genvar gi;

   assign busy = (mc_cnt_reg != 4'd0);

`ifdef HAZ_FWD_EN
   // Everything except a load still in EX is covered by the bypass network.
   assign match_rs1 = (id_rs1 != 5'd0) && sb_v_reg[0] && sb_ld_reg[0] && (sb_rd_reg[0] == id_rs1);
   assign match_rs2 = (id_rs2 != 5'd0) && sb_v_reg[0] && sb_ld_reg[0] && (sb_rd_reg[0] == id_rs2);
`else
   logic [DEPTH-1:0] hit_rs1;
   logic [DEPTH-1:0] hit_rs2;

   for (gi = 0; gi < DEPTH; gi++) begin : g_match
      assign hit_rs1[gi] = sb_v_reg[gi] && (sb_rd_reg[gi] == id_rs1);
      assign hit_rs2[gi] = sb_v_reg[gi] && (sb_rd_reg[gi] == id_rs2);
   end

   assign match_rs1 = (id_rs1 != 5'd0) && (|hit_rs1);
   assign match_rs2 = (id_rs2 != 5'd0) && (|hit_rs2);
`endif

   assign raw   = id_valid && ((id_uses_rs1 && match_rs1) || (id_uses_rs2 && match_rs2));
   assign issue = id_valid && !ex_branch_taken && !busy && !raw;

   // While busy the op parks in EX; a bubble enters MEM behind it.
   assign sb_v_next[0]  = busy ? sb_v_reg[0]  : (issue && id_writes_rd && (id_rd != 5'd0));
   assign sb_rd_next[0] = busy ? sb_rd_reg[0] : (issue ? id_rd : 5'd0);
   assign sb_ld_next[0] = busy ? sb_ld_reg[0] : (issue && id_is_load);

   for (gi = 1; gi < DEPTH; gi++) begin : g_shift
      assign sb_v_next[gi]  = (busy && gi == 1) ? 1'b0 : sb_v_reg[gi-1];
      assign sb_rd_next[gi] = (busy && gi == 1) ? 5'd0 : sb_rd_reg[gi-1];
      assign sb_ld_next[gi] = (busy && gi == 1) ? 1'b0 : sb_ld_reg[gi-1];
   end

   // The oldest entry only retires; its fields feed nothing downstream.
   assign sb_unused = ^{sb_v_reg[DEPTH-1], sb_rd_reg[DEPTH-1], sb_ld_reg[DEPTH-1]};

   always_comb begin
      mc_cnt_next = mc_cnt_reg;
      if (issue && id_multicycle) begin
         mc_cnt_next = MC_LOAD;
      end else if (busy) begin
         mc_cnt_next = mc_cnt_reg - 4'd1;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sb_v_reg   <= '0;
         sb_rd_reg  <= '0;
         sb_ld_reg  <= '0;
         mc_cnt_reg <= 4'd0;
      end else begin
         sb_v_reg   <= sb_v_next;
         sb_rd_reg  <= sb_rd_next;
         sb_ld_reg  <= sb_ld_next;
         mc_cnt_reg <= mc_cnt_next;
      end
   end

   // A branch out of a busy EX cannot happen, so busy outranks it.
   always_comb begin
      pc_stall   = 1'b0;
      ifid_stall = 1'b0;
      ifid_flush = 1'b0;
      idex_stall = 1'b0;
      idex_flush = 1'b0;
      if (!reset) begin
         ifid_flush = 1'b1;
         idex_flush = 1'b1;
      end else if (ex_branch_taken && !busy) begin
         ifid_flush = 1'b1;
         idex_flush = 1'b1;
      end else if (busy) begin
         pc_stall   = 1'b1;
         ifid_stall = 1'b1;
         idex_stall = 1'b1;
      end else if (raw) begin
         pc_stall   = 1'b1;
         ifid_stall = 1'b1;
         idex_flush = 1'b1;
      end
   end

   assign ex_busy = reset && busy;

endmodule

// File: tb/tb_p2_hazard_ctrl.sv
// Directed-vector bench for p2_hazard_ctrl (DEPTH=3, MC_CYCLES=4); expected outputs are hand-derived constants.
module tb_p2_hazard_ctrl;

   // Output vector order: {pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush, ex_busy}
   localparam logic [5:0] NONE = 6'b000000;
   localparam logic [5:0] RST  = 6'b001010;
   localparam logic [5:0] BR   = 6'b001010;
   localparam logic [5:0] RAW  = 6'b110010;
   localparam logic [5:0] BUSY = 6'b110101;

`ifdef HAZ_FWD_EN
   localparam int STALL_ALU = 0;
   localparam int STALL_LD  = 1;
`else
   localparam int STALL_ALU = 3;
   localparam int STALL_LD  = 3;
`endif

   logic       clock;
   logic       reset;
   logic       id_valid;
   logic [4:0] id_rs1;
   logic [4:0] id_rs2;
   logic       id_uses_rs1;
   logic       id_uses_rs2;
   logic [4:0] id_rd;
   logic       id_writes_rd;
   logic       id_is_load;
   logic       id_multicycle;
   logic       ex_branch_taken;
   logic       pc_stall;
   logic       ifid_stall;
   logic       ifid_flush;
   logic       idex_stall;
   logic       idex_flush;
   logic       ex_busy;
   logic [5:0] outs;

   int n_cmp = 0;
   int n_err = 0;

   p2_hazard_ctrl #(.DEPTH(3), .MC_CYCLES(4)) dut (
      .clock           (clock),
      .reset           (reset),
      .id_valid        (id_valid),
      .id_rs1          (id_rs1),
      .id_rs2          (id_rs2),
      .id_uses_rs1     (id_uses_rs1),
      .id_uses_rs2     (id_uses_rs2),
      .id_rd           (id_rd),
      .id_writes_rd    (id_writes_rd),
      .id_is_load      (id_is_load),
      .id_multicycle   (id_multicycle),
      .ex_branch_taken (ex_branch_taken),
      .pc_stall        (pc_stall),
      .ifid_stall      (ifid_stall),
      .ifid_flush      (ifid_flush),
      .idex_stall      (idex_stall),
      .idex_flush      (idex_flush),
      .ex_busy         (ex_busy)
   );

   assign outs = {pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush, ex_busy};

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %b expected %b", tag, got, exp);
      end
   endtask

   // One decode cycle: drive on the falling edge, sample 1 ns later.
   task automatic vec(input string tag, input logic v, input logic [4:0] rs1, input logic u1,
                      input logic [4:0] rs2, input logic u2, input logic [4:0] rd, input logic wr,
                      input logic ld, input logic mc, input logic br, input logic [5:0] exp);
      @(negedge clock);
      id_valid        = v;
      id_rs1          = rs1;
      id_uses_rs1     = u1;
      id_rs2          = rs2;
      id_uses_rs2     = u2;
      id_rd           = rd;
      id_writes_rd    = wr;
      id_is_load      = ld;
      id_multicycle   = mc;
      ex_branch_taken = br;
      #1;
      $display("tx %-12s valid=%0d rs1=%0d rs2=%0d rd=%0d br=%0d outs=%b exp=%b",
               tag, v, rs1, rs2, rd, br, outs, exp);
      check_eq(tag, {2'b00, outs}, {2'b00, exp});
   endtask

   task automatic idle(input string tag, input logic [5:0] exp);
      vec(tag, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, exp);
   endtask

   initial begin
      reset           = 1'b0;
      id_valid        = 1'b0;
      id_rs1          = 5'd0;
      id_rs2          = 5'd0;
      id_uses_rs1     = 1'b0;
      id_uses_rs2     = 1'b0;
      id_rd           = 5'd0;
      id_writes_rd    = 1'b0;
      id_is_load      = 1'b0;
      id_multicycle   = 1'b0;
      ex_branch_taken = 1'b0;

      // Reset held low forces the flush pattern regardless of inputs.
      idle("rst_idle", RST);
      vec("rst_active", 1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b1, RST);
      reset = 1'b1;
      idle("rel_idle", NONE);

      // ALU producer followed immediately by a consumer of x5.
      vec("add_x5", 1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, NONE);
      for (int i = 0; i < STALL_ALU; i++)
         vec("use_x5_stl", 1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, RAW);
      vec("use_x5_iss", 1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, NONE);
      for (int i = 0; i < 3; i++) idle("drain_a", NONE);

      // Load producer, consumer reads it through rs2.
      vec("ld_x7", 1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, NONE);
      for (int i = 0; i < STALL_LD; i++)
         vec("use_x7_stl", 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, RAW);
      vec("use_x7_iss", 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, NONE);
      for (int i = 0; i < 3; i++) idle("drain_b", NONE);

      // x0 never hazards; an unused source field never hazards.
      vec("ld_x0", 1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, NONE);
      vec("use_x0", 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, NONE);
      vec("ld_x9", 1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0, NONE);
      vec("x9_unused", 1'b1, 5'd9, 1'b0, 5'd9, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, NONE);
      for (int i = 0; i < 3; i++) idle("drain_c", NONE);

      // Multi-cycle op: three busy cycles (branch ignored in the first), then the next issues.
      vec("mc_issue", 1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd10, 1'b1, 1'b0, 1'b1, 1'b0, NONE);
      vec("mc_busy_br", 1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd11, 1'b1, 1'b0, 1'b0, 1'b1, BUSY);
      vec("mc_busy2", 1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd11, 1'b1, 1'b0, 1'b0, 1'b0, BUSY);
      vec("mc_busy3", 1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd11, 1'b1, 1'b0, 1'b0, 1'b0, BUSY);
      vec("mc_next", 1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd11, 1'b1, 1'b0, 1'b0, 1'b0, NONE);
      for (int i = 0; i < 3; i++) idle("drain_d", NONE);

      // Branch wins over RAW and the decode instruction is not recorded.
      vec("add_x12", 1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd12, 1'b1, 1'b0, 1'b0, 1'b0, NONE);
      vec("br_raw", 1'b1, 5'd12, 1'b1, 5'd0, 1'b0, 5'd13, 1'b1, 1'b1, 1'b0, 1'b1, BR);
      vec("use_x13", 1'b1, 5'd13, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, NONE);
      for (int i = 0; i < 3; i++) idle("drain_e", NONE);

      // Reset while the busy counter is at 2.
      vec("mc2_issue", 1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd10, 1'b1, 1'b0, 1'b1, 1'b0, NONE);
      idle("mc2_busy", BUSY);
      @(negedge clock);
      reset = 1'b0;
      #1;
      $display("tx %-12s outs=%b exp=%b", "rst_mc", outs, RST);
      check_eq("rst_mc", {2'b00, outs}, {2'b00, RST});
      @(negedge clock);
      #1;
      $display("tx %-12s outs=%b exp=%b", "rst_hold", outs, RST);
      check_eq("rst_hold", {2'b00, outs}, {2'b00, RST});
      reset = 1'b1;
      vec("post_rst_x10", 1'b1, 5'd10, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, NONE);
      idle("post_rst_idle", NONE);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
